serial_subtractor_32: RTL
=========================

# serial_subtractor_32

Bit-serial two's-complement subtractor computing `a - b` one bit per clock as `a + ~b + 1`. It reuses a single full-adder cell in place of a 32-cell ripple chain. It is the companion to the combinational 32-bit adder in the Lab1 datapath: same operand width, same carryout and overflow semantics, and it adds a zero flag. It sits beside the adder as a low-area ALU subtract path, driven by a start/done handshake.

## Interface
- `WIDTH`, default 32: operand and result width. Must be ≥ 2.
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `reset_n` input, 1 bit: reset, synchronous, active-low.
- `start` input, 1 bit: request. Sampled only in IDLE.
- `a` input, WIDTH bits: minuend. Captured on the accepting edge.
- `b` input, WIDTH bits: subtrahend. Captured on the accepting edge.
- `busy` output, 1 bit: high in RUN and DONE.
- `done` output, 1 bit: one-cycle pulse; results are valid from this cycle onward.
- `diff` output, WIDTH bits: `a - b` modulo 2^WIDTH.
- `carryout` output, 1 bit: carry out of the MSB cell. 1 means no borrow (`a >= b` unsigned).
- `overflow` output, 1 bit: carry into the MSB XOR carry out of the MSB (signed overflow).
- `zero` output, 1 bit: 1 when `diff == 0`.

## Operation
- FSM states: IDLE, RUN, DONE. Internal signals:
  - Shift registers `ra`, `rb`, `rd` (WIDTH bits each).
  - `carry` (1 bit).
  - `cnt` (clog2(WIDTH) bits).
  - `zacc` (1 bit).
- **IDLE:** if `start == 1` at an edge, load `ra = a`, `rb = b`, `carry = 1`, `cnt = 0`, `zacc = 1`, and go to RUN. Otherwise stay in IDLE.
- **RUN:** each edge processes bit `cnt` using `x = ra[0]` and `y = ~rb[0]`:
  - Sum bit `s = x ^ y ^ carry`, shifted into `rd` from the MSB end. `ra` and `rb` shift right.
  - `carry <= (x & y) | ((x ^ y) & carry)`.
  - `zacc <= zacc & ~s`.
  - `cnt` increments.
- **Last bit (`cnt == WIDTH-1`):** on this edge, additionally:
  - `diff <= final rd`.
  - `carryout <= new carry`.
  - `overflow <= carry (pre-update) ^ new carry`.
  - `zero <= final zacc`.
  - Go to DONE.
- **DONE:** `done = 1` for exactly one cycle, then unconditionally go to IDLE.
- `start` in RUN or DONE is ignored; it is not queued. A new request requires `start` high while in IDLE.
- `a` and `b` may change freely after the accepting edge.
- Result outputs (`diff`, `carryout`, `overflow`, `zero`) change only on the last-bit edge. They hold their values through IDLE until the next operation completes.
- **Reset** (`reset_n == 0` at an edge, in any state, including mid-RUN):
  - State = IDLE, `busy = 0`, `done = 0`, `diff = 0`, `carryout = 0`, `overflow = 0`, `zero = 0`.
  - Internal registers cleared.
  - A partial operation is discarded; no `done` is produced for it.
- `busy` and `done` are decoded from registered state only. They are glitch-free and have no combinational path from `start`.

## Timing
- Accept at edge k, when IDLE and `start = 1`.
- `busy` is high from edge k+1 through edge k+WIDTH+1.
- Bits 0..WIDTH-1 are processed on edges k+1..k+WIDTH.
- Results are registered on edge k+WIDTH.
- `done` is high in the cycle between edges k+WIDTH and k+WIDTH+1.
- The block is back in IDLE after edge k+WIDTH+1.
- Latency from accept to `done`: WIDTH cycles (32 by default).
- Minimum spacing between accepts: WIDTH+2 cycles (34).
- `start` held high continuously gives back-to-back operations at that spacing.
- If `start = 1` and `reset_n = 0` on the same edge, reset wins and the request is not accepted.

## Test plan
- **Reset values:** hold `reset_n = 0` for 2 edges. All outputs = 0, `busy = 0`.
- **Reset mid-operation:** start, then deassert `reset_n` at bit 10. Next cycle: IDLE, all outputs 0, no `done` pulse follows.
- **Handshake timing:**
  - Accept on edge k, then `done` high exactly in cycle k+32, for 1 cycle.
  - Pulsing `start` during RUN and DONE does not change results or timing.
  - `start` held high gives accepts 34 cycles apart.
- **Basic and zero cases:**
  - 5 − 3 → `diff` = 0x00000002, `carryout = 1`, `overflow = 0`, `zero = 0`.
  - 7 − 7 → `diff` = 0x00000000, `carryout = 1`, `zero = 1`.
  - 0 − 0 → `diff` = 0, `carryout = 1`, `zero = 1`.
- **Borrow and carry propagation:**
  - 0 − 1 → `diff` = 0xFFFFFFFF, `carryout = 0`, `overflow = 0`.
  - 0x00040000 − 1 → `diff` = 0x0003FFFF, `carryout = 1`.
- **Signed overflow:**
  - 0x80000000 − 1 → `diff` = 0x7FFFFFFF, `overflow = 1`, `carryout = 1`.
  - 0x7FFFFFFF − 0xFFFFFFFF → `diff` = 0x80000000, `overflow = 1`, `carryout = 0`.
  - Random regression: 1000 operand pairs checked against `a - b`, with the flags checked by a reference model.

Source files
------------

// File: rtl/serial_subtractor_32.sv
// Bit-serial two's-complement subtractor: a - b computed as a + ~b + 1, one bit per clock,
// through a single full-adder cell. A start/done handshake frames each operation.
module serial_subtractor_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_carryout,
    output logic             o_overflow,
    output logic             o_zero
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic             w_step;

    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_rd;
    logic             r_carry;
    logic [CntW-1:0]  r_cnt;
    logic             r_zacc;

    logic [WIDTH-1:0] r_diff;
    logic             r_carryout;
    logic             r_overflow;
    logic             r_zero;

    // Full-adder cell operating on the current LSBs; subtrahend bit is inverted.
    logic             w_x;
    logic             w_y;
    logic             w_s;
    logic             w_carry_nxt;
    logic [WIDTH-1:0] w_rd_nxt;
    logic             w_zacc_nxt;
    logic             w_last;

    assign w_x         = r_ra[0];
    assign w_y         = ~r_rb[0];
    assign w_s         = w_x ^ w_y ^ r_carry;
    assign w_carry_nxt = (w_x & w_y) | ((w_x ^ w_y) & r_carry);
    assign w_rd_nxt    = {w_s, r_rd[WIDTH-1:1]};
    assign w_zacc_nxt  = r_zacc & ~w_s;
    assign w_last      = (r_cnt == LastCnt);

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus load/step strobes; busy/done depend on registered state only.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                o_busy = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Operand shift registers, serial accumulators and result registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_ra       <= '0;
            r_rb       <= '0;
            r_rd       <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_zacc     <= 1'b0;
            r_diff     <= '0;
            r_carryout <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_load) begin
            r_ra    <= i_a;
            r_rb    <= i_b;
            r_rd    <= '0;
            r_carry <= 1'b1;  // the +1 of a + ~b + 1
            r_cnt   <= '0;
            r_zacc  <= 1'b1;
        end else if (w_step) begin
            r_ra    <= {1'b0, r_ra[WIDTH-1:1]};
            r_rb    <= {1'b0, r_rb[WIDTH-1:1]};
            r_rd    <= w_rd_nxt;
            r_carry <= w_carry_nxt;
            r_cnt   <= r_cnt + 1'b1;
            r_zacc  <= w_zacc_nxt;
            if (w_last) begin
                r_diff     <= w_rd_nxt;
                r_carryout <= w_carry_nxt;
                // r_carry here is the carry into the MSB cell.
                r_overflow <= r_carry ^ w_carry_nxt;
                r_zero     <= w_zacc_nxt;
            end
        end
    end

    assign o_diff     = r_diff;
    assign o_carryout = r_carryout;
    assign o_overflow = r_overflow;
    assign o_zero     = r_zero;

endmodule
